// File: rtl/cond_logic.sv
// Holds the architectural NZCV flags and evaluates the ARM condition field against them.
// CondEx/PCSrc/RegWrite/MemWrite are combinational; flag writes appear one cycle later.
// No handshake: Stall freezes flag updates only and never gates the write enables.
module cond_logic #(
  parameter logic [3:0] FLAG_RESET = 4'b0000,
  parameter logic       NV_EXEC    = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       NoWrite,
  input  logic       MemW,
  input  logic       Stall,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CarryFlag,
  output logic [3:0] Flags,
  output logic       CondEx
);

  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       cond_ex;

  assign flag_n = nz_q[1];
  assign flag_z = nz_q[0];
  assign flag_c = cv_q[1];
  assign flag_v = cv_q[0];

  // Evaluated only from registered flags, so set-and-test in one cycle sees old flags.
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = NV_EXEC;
    endcase
  end

  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (cond_ex && !Stall) begin
      if (FlagW[1]) nz_d = ALUFlags[3:2];
      if (FlagW[0]) cv_d = ALUFlags[1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      nz_q <= FLAG_RESET[3:2];
      cv_q <= FLAG_RESET[1:0];
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

  assign CondEx    = cond_ex;
  assign PCSrc     = PCS & cond_ex;
  assign RegWrite  = RegW & ~NoWrite & cond_ex;
  assign MemWrite  = MemW & cond_ex;
  assign CarryFlag = cv_q[1];
  assign Flags     = {nz_q, cv_q};

endmodule

// File: tb/tb_cond_logic.sv
// Bench for cond_logic: directed scenarios plus randomized traffic against a flag model.
module tb_cond_logic;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, NoWrite, MemW, Stall;
  logic       PCSrc, RegWrite, MemWrite, CarryFlag, CondEx;
  logic [3:0] Flags;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] m_flags;

  always #5 CLK = ~CLK;

  cond_logic dut (
    .CLK(CLK), .RESET(RESET), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .NoWrite(NoWrite), .MemW(MemW), .Stall(Stall),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .CarryFlag(CarryFlag), .Flags(Flags), .CondEx(CondEx)
  );

  // Condition table written as the architectural rules on named flag values.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0:  return z;
      1:  return !z;
      2:  return cy;
      3:  return !cy;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return cy && !z;
      9:  return !cy || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Advance the model using the inputs present at the edge, then step the DUT.
  task automatic tick();
    logic pass;
    pass = ref_pass(Cond, m_flags);
    if (RESET) m_flags = 4'h0;
    else if (pass && !Stall) begin
      if (FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
      if (FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    RESET = 1'b0; Cond = 4'b1110; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; NoWrite = 1'b0; MemW = 1'b0; Stall = 1'b0;
  endtask

  task automatic load_flags(input logic [3:0] f);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f; Stall = 1'b0;
    tick();
    FlagW = 2'b00;
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET = 1'b1; FlagW = 2'b11; ALUFlags = 4'hF;
    tick();
    RESET = 1'b0; FlagW = 2'b00;
    n_checks++;
    if (Flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got=%h exp=0", Flags); end
    n_checks++;
    if (CarryFlag !== 1'b0) begin n_fail++; $display("FAIL reset_carry got=%b exp=0", CarryFlag); end
  endtask

  task automatic test_set_flags();
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0110;
    tick();
    FlagW = 2'b00;
    n_checks++;
    if (Flags !== 4'b0110) begin n_fail++; $display("FAIL set_flags got=%b exp=0110", Flags); end
    n_checks++;
    if (CarryFlag !== 1'b1) begin n_fail++; $display("FAIL set_carry got=%b exp=1", CarryFlag); end
    Cond = 4'b0000; #1;
    n_checks++;
    if (CondEx !== 1'b1) begin n_fail++; $display("FAIL eq_pass got=%b exp=1", CondEx); end
    Cond = 4'b0001; #1;
    n_checks++;
    if (CondEx !== 1'b0) begin n_fail++; $display("FAIL ne_fail got=%b exp=0", CondEx); end
  endtask

  task automatic test_partial_update();
    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1000;
    tick();
    FlagW = 2'b00;
    n_checks++;
    if (Flags !== 4'b1010) begin n_fail++; $display("FAIL nz_only got=%b exp=1010", Flags); end
    Cond = 4'b1010; #1;
    n_checks++;
    if (CondEx !== 1'b0) begin n_fail++; $display("FAIL ge got=%b exp=0", CondEx); end
    Cond = 4'b1011; #1;
    n_checks++;
    if (CondEx !== 1'b1) begin n_fail++; $display("FAIL lt got=%b exp=1", CondEx); end
  endtask

  task automatic test_failed_cond();
    load_flags(4'h0);
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'hF;
    PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0;
    #1;
    n_checks++;
    if ({CondEx, PCSrc, RegWrite, MemWrite} !== 4'b0000) begin
      n_fail++; $display("FAIL failed_cond_gates got=%b exp=0000", {CondEx, PCSrc, RegWrite, MemWrite});
    end
    tick();
    n_checks++;
    if (Flags !== 4'h0) begin n_fail++; $display("FAIL failed_cond_hold got=%h exp=0", Flags); end
    Cond = 4'b1110; #1;
    n_checks++;
    if ({PCSrc, RegWrite, MemWrite} !== 3'b111) begin
      n_fail++; $display("FAIL al_gates got=%b exp=111", {PCSrc, RegWrite, MemWrite});
    end
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; FlagW = 2'b00;
  endtask

  task automatic test_stall();
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0001; Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (Flags !== 4'h0) begin n_fail++; $display("FAIL stall_hold[%0d] got=%b exp=0000", i, Flags); end
    end
    Stall = 1'b0;
    tick();
    FlagW = 2'b00;
    n_checks++;
    if (Flags !== 4'b0001) begin n_fail++; $display("FAIL stall_release got=%b exp=0001", Flags); end
  endtask

  task automatic test_sweep();
    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      n_checks++;
      if (Flags !== 4'(f)) begin n_fail++; $display("FAIL sweep_load got=%h exp=%h", Flags, 4'(f)); end
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c); #1;
        n_checks++;
        if (CondEx !== ref_pass(4'(c), 4'(f))) begin
          n_fail++; $display("FAIL sweep_cond c=%h f=%h got=%b exp=%b", c, f, CondEx, ref_pass(4'(c), 4'(f)));
        end
      end
    end
    Cond = 4'b1110; RegW = 1'b1; NoWrite = 1'b1; #1;
    n_checks++;
    if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL nowrite got=%b exp=0", RegWrite); end
    RegW = 1'b0; NoWrite = 1'b0;
  endtask

  task automatic test_reset_mid();
    load_flags(4'hF);
    RESET = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'hF;
    tick();
    RESET = 1'b0; FlagW = 2'b00;
    n_checks++;
    if (Flags !== 4'h0) begin n_fail++; $display("FAIL reset_mid got=%h exp=0", Flags); end
  endtask

  task automatic test_random();
    logic pass;
    for (int i = 0; i < 400; i++) begin
      RESET    = ($urandom_range(0, 24) == 0);
      Cond     = 4'($urandom_range(0, 15));
      ALUFlags = 4'($urandom_range(0, 15));
      FlagW    = 2'($urandom_range(0, 3));
      Stall    = ($urandom_range(0, 3) == 0);
      PCS      = 1'($urandom_range(0, 1));
      RegW     = 1'($urandom_range(0, 1));
      NoWrite  = 1'($urandom_range(0, 1));
      MemW     = 1'($urandom_range(0, 1));
      #1;
      pass = ref_pass(Cond, m_flags);
      n_checks++;
      if ({Flags, CarryFlag} !== {m_flags, m_flags[1]}) begin
        n_fail++; $display("FAIL rand_flags i=%0d got=%h/%b exp=%h/%b", i, Flags, CarryFlag, m_flags, m_flags[1]);
      end
      n_checks++;
      if ({CondEx, PCSrc, RegWrite, MemWrite} !== {pass, PCS & pass, RegW & ~NoWrite & pass, MemW & pass}) begin
        n_fail++;
        $display("FAIL rand_outs i=%0d got=%b exp=%b", i, {CondEx, PCSrc, RegWrite, MemWrite},
                 {pass, PCS & pass, RegW & ~NoWrite & pass, MemW & pass});
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_set_flags();
    test_partial_update();
    test_failed_cond();
    test_stall();
    test_sweep();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
